// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Control unit for the multicycle 16-bit processor. A Moore FSM steps each
// instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). It also keeps
// the privilege bit, sends faults (illegal opcode, ALU overflow) to TRAP, and
// parks the core in HALT.
//
// Ports
//   clock          rising-edge system clock
//   reset          asynchronous active-low reset
//   instruction    fetched instruction: opcode [15:12], alu_funct [11:8]
//   overflow       ALU overflow, only looked at in EXEC
//   MemWrite .. AluOp   datapath controls (Moore: state + latched opcode/funct)
//   in_kernel      privilege mode bit (1 = kernel)
//   state_out      current state code
//   illegal_op     high during EXEC of an opcode in 0x8..0xD
// ---------------------------------------------------------------------------
module multicycle_control (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic        overflow,
    output logic        MemWrite,
    output logic [1:0]  MemSrc,
    output logic [2:0]  MemDst,
    output logic [3:0]  PCSrc,
    output logic [1:0]  SPSrc,
    output logic        PCWrite,
    output logic        SPWrite,
    output logic        InstWrite,
    output logic        mary_write,
    output logic        shelley_write,
    output logic        comp_write,
    output logic        ra_write,
    output logic [2:0]  mary_src,
    output logic [1:0]  shelley_src,
    output logic        ra_src,
    output logic        SrcA,
    output logic [1:0]  SrcB,
    output logic [3:0]  AluOp,
    output logic        in_kernel,
    output logic [2:0]  state_out,
    output logic        illegal_op
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_ALU  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LW   = 4'h2;
    localparam logic [3:0] OP_SW   = 4'h3;
    localparam logic [3:0] OP_JAL  = 4'h4;
    localparam logic [3:0] OP_JR   = 4'h5;
    localparam logic [3:0] OP_PUSH = 4'h6;
    localparam logic [3:0] OP_POP  = 4'h7;
    localparam logic [3:0] OP_USER = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t     state_q, state_d;
    logic [3:0] opcode_q, opcode_d;
    logic [3:0] funct_q, funct_d;
    logic       in_kernel_q, in_kernel_d;
    logic       illegal_opc;

    // The immediate field is decoded by the datapath, not here.
    logic unused_imm;
    assign unused_imm = ^instruction[7:0];

    assign illegal_opc = (opcode_q >= 4'h8) && (opcode_q <= 4'hD);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            opcode_q    <= 4'h0;
            funct_q     <= 4'h0;
            in_kernel_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            funct_q     <= funct_d;
            in_kernel_q <= in_kernel_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        funct_d     = funct_q;
        in_kernel_d = in_kernel_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                opcode_d = instruction[15:12];
                funct_d  = instruction[11:8];
                state_d  = (instruction[15:12] == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode_q)
                    OP_ALU, OP_ADDI:               state_d = overflow ? S_TRAP : S_WB;
                    OP_LW, OP_SW, OP_PUSH, OP_POP: state_d = S_MEM;
                    OP_USER:                       in_kernel_d = 1'b0;
                    default: if (illegal_opc)      state_d = S_TRAP;
                endcase
            end
            S_MEM:   state_d = (opcode_q == OP_LW) ? S_WB : S_FETCH;
            S_WB:    state_d = S_FETCH;
            S_TRAP: begin
                state_d     = S_FETCH;
                in_kernel_d = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;   // unused code 7 recovers to FETCH
        endcase
    end

    // Moore outputs: depend only on state and the latched opcode/funct
    always_comb begin
        MemWrite      = 1'b0;
        MemSrc        = 2'd0;
        MemDst        = 3'd0;
        PCSrc         = 4'd0;
        SPSrc         = 2'd0;
        PCWrite       = 1'b0;
        SPWrite       = 1'b0;
        InstWrite     = 1'b0;
        mary_write    = 1'b0;
        shelley_write = 1'b0;
        comp_write    = 1'b0;
        ra_write      = 1'b0;
        mary_src      = 3'd0;
        shelley_src   = 2'd0;
        ra_src        = 1'b0;
        SrcA          = 1'b0;
        SrcB          = 2'd0;
        AluOp         = 4'd0;
        illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                InstWrite = 1'b1;
                PCWrite   = 1'b1;
            end
            S_EXEC: begin
                case (opcode_q)
                    OP_ALU: begin
                        AluOp      = funct_q;
                        comp_write = 1'b1;
                    end
                    OP_ADDI: begin
                        SrcB       = 2'd1;
                        comp_write = 1'b1;
                    end
                    OP_LW, OP_SW: begin
                        SrcB       = 2'd2;
                        comp_write = 1'b1;
                    end
                    OP_JAL: begin
                        ra_write = 1'b1;
                        PCWrite  = 1'b1;
                        PCSrc    = 4'd1;
                    end
                    OP_JR: begin
                        PCWrite = 1'b1;
                        PCSrc   = 4'd2;
                    end
                    OP_PUSH: begin
                        SPWrite = 1'b1;
                        SPSrc   = 2'd1;
                    end
                    OP_POP:  MemSrc = 2'd2;
                    default: illegal_op = illegal_opc;
                endcase
            end
            S_MEM: begin
                case (opcode_q)
                    OP_LW: MemSrc = 2'd1;
                    OP_SW: begin
                        MemWrite = 1'b1;
                        MemSrc   = 2'd1;
                    end
                    OP_PUSH: begin
                        MemWrite = 1'b1;
                        MemSrc   = 2'd2;
                    end
                    OP_POP: begin
                        mary_write = 1'b1;
                        mary_src   = 3'd2;
                        SPWrite    = 1'b1;
                        SPSrc      = 2'd2;
                    end
                    default: ;
                endcase
            end
            S_WB: begin
                mary_write = 1'b1;
                mary_src   = (opcode_q == OP_LW) ? 3'd2 : 3'd1;
            end
            S_TRAP: begin
                ra_write = 1'b1;
                PCWrite  = 1'b1;
                PCSrc    = 4'd3;
            end
            default: ;
        endcase
    end

    assign state_out = state_q;
    assign in_kernel = in_kernel_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instruction = 16'h0;
    logic        overflow = 1'b0;
    logic        MemWrite, PCWrite, SPWrite, InstWrite, mary_write, shelley_write;
    logic        comp_write, ra_write, ra_src, SrcA, in_kernel, illegal_op;
    logic [1:0]  MemSrc, SPSrc, shelley_src, SrcB;
    logic [2:0]  MemDst, mary_src, state_out;
    logic [3:0]  PCSrc, AluOp;

    always #5 clock = ~clock;

    multicycle_control dut (
        .clock(clock), .reset(reset), .instruction(instruction), .overflow(overflow),
        .MemWrite(MemWrite), .MemSrc(MemSrc), .MemDst(MemDst), .PCSrc(PCSrc),
        .SPSrc(SPSrc), .PCWrite(PCWrite), .SPWrite(SPWrite), .InstWrite(InstWrite),
        .mary_write(mary_write), .shelley_write(shelley_write), .comp_write(comp_write),
        .ra_write(ra_write), .mary_src(mary_src), .shelley_src(shelley_src),
        .ra_src(ra_src), .SrcA(SrcA), .SrcB(SrcB), .AluOp(AluOp),
        .in_kernel(in_kernel), .state_out(state_out), .illegal_op(illegal_op)
    );

    typedef struct packed {
        logic       MemWrite;
        logic [1:0] MemSrc;
        logic [2:0] MemDst;
        logic [3:0] PCSrc;
        logic [1:0] SPSrc;
        logic       PCWrite;
        logic       SPWrite;
        logic       InstWrite;
        logic       mary_write;
        logic       shelley_write;
        logic       comp_write;
        logic       ra_write;
        logic [2:0] mary_src;
        logic [1:0] shelley_src;
        logic       ra_src;
        logic       SrcA;
        logic [1:0] SrcB;
        logic [3:0] AluOp;
    } ctrl_t;

    ctrl_t act;
    assign act = {MemWrite, MemSrc, MemDst, PCSrc, SPSrc, PCWrite, SPWrite, InstWrite,
                  mary_write, shelley_write, comp_write, ra_write, mary_src, shelley_src,
                  ra_src, SrcA, SrcB, AluOp};

    typedef struct {
        logic [2:0] st;
        ctrl_t      c;
        logic       ill;
        logic       kern;
    } exp_t;

    typedef struct {
        logic [15:0]     instr;
        logic            ovf;
        int              len;
        logic [4:0][2:0] seq;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[15];
    int   checks = 0;
    int   failures = 0;
    logic kern = 1'b1;

    // Expected controls for one state of one instruction.
    function automatic ctrl_t model(input logic [2:0] st, input logic [3:0] op, input logic [3:0] fn);
        ctrl_t c;
        c = '0;
        case (st)
            3'd0: begin c.InstWrite = 1; c.PCWrite = 1; end
            3'd2: case (op)
                4'h0: begin c.AluOp = fn; c.comp_write = 1; end
                4'h1: begin c.SrcB = 1; c.comp_write = 1; end
                4'h2, 4'h3: begin c.SrcB = 2; c.comp_write = 1; end
                4'h4: begin c.ra_write = 1; c.PCWrite = 1; c.PCSrc = 1; end
                4'h5: begin c.PCWrite = 1; c.PCSrc = 2; end
                4'h6: begin c.SPWrite = 1; c.SPSrc = 1; end
                4'h7: c.MemSrc = 2;
                default: ;
            endcase
            3'd3: case (op)
                4'h2: c.MemSrc = 1;
                4'h3: begin c.MemWrite = 1; c.MemSrc = 1; end
                4'h6: begin c.MemWrite = 1; c.MemSrc = 2; end
                4'h7: begin c.mary_write = 1; c.mary_src = 2; c.SPWrite = 1; c.SPSrc = 2; end
                default: ;
            endcase
            3'd4: begin c.mary_write = 1; c.mary_src = (op == 4'h2) ? 3'd2 : 3'd1; end
            3'd5: begin c.ra_write = 1; c.PCWrite = 1; c.PCSrc = 3; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [4:0][2:0] seq5(input int s0, input int s1, input int s2,
                                             input int s3, input int s4);
        logic [4:0][2:0] r;
        r[0] = s0[2:0]; r[1] = s1[2:0]; r[2] = s2[2:0]; r[3] = s3[2:0]; r[4] = s4[2:0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    // Drive one instruction starting in FETCH; expectations are queued when the
    // instruction is driven and popped each cycle as the DUT produces them.
    task automatic run_instr(input vec_t v);
        exp_t       e;
        logic [3:0] op;
        op = v.instr[15:12];
        instruction = v.instr;
        overflow = v.ovf;
        for (int k = 0; k < v.len; k++) begin
            e.st   = v.seq[k];
            e.c    = model(v.seq[k], op, v.instr[11:8]);
            e.ill  = (v.seq[k] == 3'd2) && (op >= 4'h8) && (op <= 4'hD);
            e.kern = kern;
            sb.push_back(e);
            if (v.seq[k] == 3'd2 && op == 4'hE) kern = 1'b0;
            if (v.seq[k] == 3'd5) kern = 1'b1;
        end
        for (int k = 0; k < v.len; k++) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("state[%h:%0d]", v.instr, k), {29'd0, state_out}, {29'd0, e.st});
                chk($sformatf("ctrl[%h:%0d]", v.instr, k), act, e.c);
                chk($sformatf("illegal[%h:%0d]", v.instr, k), {31'd0, illegal_op}, {31'd0, e.ill});
                chk($sformatf("kernel[%h:%0d]", v.instr, k), {31'd0, in_kernel}, {31'd0, e.kern});
            end
            @(negedge clock);
        end
        overflow = 1'b0;
        $display("instr=%h ovf=%b cycles=%0d in_kernel=%b", v.instr, v.ovf, v.len, in_kernel);
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_state"}, {29'd0, state_out}, 32'd0);
        chk({nm, "_kernel"}, {31'd0, in_kernel}, 32'd1);
        chk({nm, "_illegal"}, {31'd0, illegal_op}, 32'd0);
        chk({nm, "_memwrite"}, {31'd0, MemWrite}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{16'h0300, 1'b0, 4, seq5(0, 1, 2, 4, 0)};   // ALU funct 3
        vecs[1]  = '{16'h1705, 1'b0, 4, seq5(0, 1, 2, 4, 0)};   // ADDI
        vecs[2]  = '{16'h2312, 1'b0, 5, seq5(0, 1, 2, 3, 4)};   // LW
        vecs[3]  = '{16'h3312, 1'b0, 4, seq5(0, 1, 2, 3, 0)};   // SW
        vecs[4]  = '{16'h4ABC, 1'b0, 3, seq5(0, 1, 2, 0, 0)};   // JAL
        vecs[5]  = '{16'h5000, 1'b0, 3, seq5(0, 1, 2, 0, 0)};   // JR
        vecs[6]  = '{16'h6000, 1'b0, 4, seq5(0, 1, 2, 3, 0)};   // PUSH
        vecs[7]  = '{16'h7000, 1'b0, 4, seq5(0, 1, 2, 3, 0)};   // POP
        vecs[8]  = '{16'h1234, 1'b1, 4, seq5(0, 1, 2, 5, 0)};   // ADDI overflow
        vecs[9]  = '{16'h0C00, 1'b1, 4, seq5(0, 1, 2, 5, 0)};   // ALU overflow
        vecs[10] = '{16'h0F00, 1'b0, 4, seq5(0, 1, 2, 4, 0)};   // ALU funct F
        vecs[11] = '{16'hE000, 1'b0, 3, seq5(0, 1, 2, 0, 0)};   // USER
        vecs[12] = '{16'h9000, 1'b0, 4, seq5(0, 1, 2, 5, 0)};   // illegal
        vecs[13] = '{16'h8000, 1'b0, 4, seq5(0, 1, 2, 5, 0)};   // illegal, low edge
        vecs[14] = '{16'hD000, 1'b0, 4, seq5(0, 1, 2, 5, 0)};   // illegal, high edge

        // Reset state
        repeat (2) @(negedge clock);
        check_reset_state("reset");
        reset = 1'b1;

        for (int i = 0; i < 15; i++) run_instr(vecs[i]);

        // USER drops privilege, then reset in the MEM cycle of a store.
        run_instr(vecs[11]);
        instruction = 16'h3456;
        repeat (3) @(negedge clock);
        chk("sw_mem_state", {29'd0, state_out}, 32'd3);
        chk("sw_mem_memwrite", {31'd0, MemWrite}, 32'd1);
        chk("sw_mem_kernel", {31'd0, in_kernel}, 32'd0);
        #2 reset = 1'b0;
        #1 check_reset_state("abort_sw");
        @(negedge clock);
        check_reset_state("abort_sw_held");
        reset = 1'b1;
        kern = 1'b1;
        $display("reset during SW MEM, state=%0d in_kernel=%b", state_out, in_kernel);
        run_instr(vecs[0]);

        // HALT: holds with every control low until reset.
        run_instr('{16'hF123, 1'b0, 3, seq5(0, 1, 6, 0, 0)});
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("halt_state[%0d]", c), {29'd0, state_out}, 32'd6);
            chk($sformatf("halt_ctrl[%0d]", c), act, 32'd0);
            @(negedge clock);
        end
        #2 reset = 1'b0;
        #1 check_reset_state("halt_reset");
        @(negedge clock);
        reset = 1'b1;
        $display("reset out of HALT, state=%0d", state_out);
        run_instr(vecs[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 One clock; reset is asynchronous and active-low.
REQ-002 clock  in  1  rising-edge system clock.
REQ-003 reset  in  1  asynchronous active-low reset.
REQ-004 instruction  in  16  fetched instruction; opcode = instruction[15:12], alu_funct = instruction[11:8].
REQ-005 overflow  in  1  ALU overflow from datapath, sampled only in EXEC.
REQ-006 Outputs, each a datapath control: MemWrite 1, MemSrc 2, MemDst 3, PCSrc 4, SPSrc 2, PCWrite 1, SPWrite 1, InstWrite 1, mary_write 1, shelley_write 1, comp_write 1, ra_write 1, mary_src 3, shelley_src 2, ra_src 1, SrcA 1, SrcB 2, AluOp 4.
REQ-007 in_kernel  out  1  privilege mode bit.
REQ-008 state_out  out  3  current state code; illegal_op  out  1  one-cycle pulse.

Function
REQ-009 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5, HALT=6; code 7 SHALL go to FETCH.
REQ-010 Outputs SHALL be Moore: a function of state, latched opcode and latched alu_funct only; every control not listed for a state SHALL be 0.
REQ-011 FETCH: InstWrite=1, PCWrite=1, PCSrc=0 (PC+2), MemSrc=0 (PC address); next DECODE.
REQ-012 DECODE: opcode and alu_funct SHALL be latched from instruction; no writes; next EXEC, or HALT for opcode 0xF.
REQ-013 Opcode 0x0 ALU: EXEC SrcA=0, SrcB=0, AluOp=alu_funct, comp_write=1; WB mary_write=1, mary_src=1 (ALU); 4 cycles total.
REQ-014 Opcode 0x1 ADDI: EXEC SrcB=1 (sext imm), AluOp=0, comp_write=1; WB as 0x0; 4 cycles.
REQ-015 Opcode 0x2 LW: EXEC SrcB=2 (sext_ls imm), AluOp=0, comp_write=1; MEM MemSrc=1 (comp address); WB mary_write=1, mary_src=2 (memory); 5 cycles.
REQ-016 Opcode 0x3 SW: EXEC as LW; MEM MemWrite=1, MemSrc=1, MemDst=0 (mary data); no WB; 4 cycles.
REQ-017 Opcode 0x4 JAL: EXEC ra_write=1, ra_src=0 (PC), PCWrite=1, PCSrc=1 (zext imm target); next FETCH; 3 cycles.
REQ-018 Opcode 0x5 JR: EXEC PCWrite=1, PCSrc=2 (ra); 3 cycles.
REQ-019 Opcode 0x6 PUSH: EXEC SPWrite=1, SPSrc=1 (SP-2); MEM MemWrite=1, MemSrc=2 (SP), MemDst=0; 4 cycles.
REQ-020 Opcode 0x7 POP: EXEC MemSrc=2; MEM mary_write=1, mary_src=2, SPWrite=1, SPSrc=2 (SP+2); 4 cycles.
REQ-021 Opcode 0xE USER: EXEC SHALL clear in_kernel at the clock edge leaving EXEC; 3 cycles.
REQ-022 Opcodes 0x8-0xD SHALL pulse illegal_op=1 during EXEC and go to TRAP.
REQ-023 overflow=1 in EXEC of opcode 0x0 or 0x1 SHALL go to TRAP instead of WB; mary_write SHALL NOT assert for that instruction.
REQ-024 TRAP: ra_write=1, ra_src=0, PCWrite=1, PCSrc=3 (trap vector); in_kernel SHALL set at the clock edge leaving TRAP; next FETCH.
REQ-025 HALT SHALL hold with all controls 0 until reset.
REQ-026 At most one of MemWrite/PCWrite-source conflicts: MemWrite and InstWrite SHALL never both be 1 in a cycle.

Reset
REQ-027 reset=0 SHALL immediately force state FETCH, in_kernel=1, latched opcode/funct=0 and illegal_op=0, including mid-instruction.
REQ-028 First FETCH SHALL occur in the first clock edge after reset deasserts; an aborted instruction's remaining writes SHALL NOT occur.

Verification
REQ-029 After reset, instruction=0x0300 (ALU, funct 3): state sequence 0,1,2,4,0; AluOp=3 in EXEC; mary_write=1 only in WB.
REQ-030 LW 0x2xxx then SW 0x3xxx: LW 5 cycles, mary_src=2 in WB; SW MemWrite=1 exactly one cycle (MEM), never in FETCH.
REQ-031 ADDI with overflow=1 in EXEC: state 0,1,2,5,0; mary_write never 1; PCSrc=3, ra_write=1 in TRAP; in_kernel=1 afterward.
REQ-032 USER 0xE000 then opcode 0x9: in_kernel 1->0 after USER EXEC; illegal_op one-cycle pulse; TRAP; in_kernel back to 1.
REQ-033 reset pulse while in MEM of SW: MemWrite drops to 0 immediately; state_out=0; in_kernel=1.
REQ-034 Opcode 0xF: DECODE->HALT, all controls 0 for 20 cycles; reset restarts FETCH.
